i2c_master_controller: RTL and testbench

Single-master I2C controller that sequences one-byte transactions to the team's I2C slave on the shared open-drain sda/scl bus.
- Host side: simple req/done handshake carrying the 7-bit address, the read/write bit and the write data.
- Bus side: generates START, address, data, ACK/NACK and STOP with a clock-divided SCL.
- Each transaction is either one byte written or one byte read.

---
 rtl/i2c_pkg.sv | 45 ++++
 rtl/i2c_master_controller_if.sv | 14 +
 rtl/i2c_quarter_tick.sv | 57 +++++
 rtl/i2c_master_controller.sv | 132 +++++++++++++
 tb/tb_i2c_master_controller.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller and its quarter-tick divider.
// The per-quarter bus drive table lives here so the FSM only has to pick the next state.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP, DONE
  } state_e;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_e;

  localparam logic       RW_WRITE   = 1'b0;
  localparam logic       RW_READ    = 1'b1;
  localparam logic [6:0] SLAVE_ADDR = 7'b0101010;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } i2c_req_t;

  // Returns {scl_low, sda_low} for the given state and quarter; 1 means pull the line low.
  function automatic logic [1:0] bus_drive(state_e st, qphase_e q, logic txbit);
    logic scl_low, sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      START: begin
        scl_low = (q == Q3);
        sda_low = (q != Q0);
      end
      ADDR, WDATA: begin
        scl_low = (q == Q0) || (q == Q1);
        sda_low = ~txbit;
      end
      ADDR_ACK, WACK, RDATA, RNACK: scl_low = (q == Q0) || (q == Q1);
      STOP: begin
        scl_low = (q == Q0) || (q == Q1);
        sda_low = (q == Q1) || (q == Q2);
      end
      default: ;
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage

// File: rtl/i2c_master_controller_if.sv
// Host-side request/done handshake of the I2C master controller.
interface i2c_master_controller_if;
  logic       req;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_err;

  modport master (output req, addr, rw, wdata, input busy, done, rdata, ack_err);
  modport slave  (input req, addr, rw, wdata, output busy, done, rdata, ack_err);
endinterface

// File: rtl/i2c_quarter_tick.sv
// CLK_DIV divider producing the SCL quarter pulse and 2-bit quarter phase.
// With I2C_CLK_STRETCH_EN defined, the hold input freezes the divider.
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
`ifdef I2C_CLK_STRETCH_EN
  input  logic    hold,
`endif
  output logic    tick,
  output logic    first,
  output qphase_e phase
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  qphase_e       phase_q, phase_d;
  logic          stall;

`ifdef I2C_CLK_STRETCH_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  assign tick  = en && !stall && (cnt_q == CW'(CLK_DIV - 1));
  assign first = (cnt_q == '0);
  assign phase = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = qphase_e'(phase_q + 2'd1);
    end else if (!stall) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/i2c_master_controller.sv
// Single-master I2C controller: one-byte write or read per req/done handshake.
// Optional SCL clock stretching is enabled with the I2C_CLK_STRETCH_EN macro.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  i2c_master_controller_if.slave  host,
  inout  wire                     sda,
  inout  wire                     scl
);
  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  i2c_req_t   req_q, req_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       run, tick, first, hold, sample, last;
  logic [7:0] txbyte;
  qphase_e    phase, phase_n;

  assign run = (state_q != IDLE) && (state_q != DONE);

`ifdef I2C_CLK_STRETCH_EN
  assign hold = (phase == Q2) && !scl;
`else
  assign hold = 1'b0;
`endif

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
`ifdef I2C_CLK_STRETCH_EN
    .hold  (hold),
`endif
    .tick  (tick),
    .first (first),
    .phase (phase)
  );

  // SDA is sampled on the first clk of quarter 2 that sees SCL actually high.
  assign sample  = run && (phase == Q2) && first && !hold;
  assign last    = tick && (phase == Q3);
  assign phase_n = tick ? qphase_e'(phase + 2'd1) : phase;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    case (state_q)
      IDLE: if (host.req) begin
        req_d     = '{addr: host.addr, rw: host.rw, wdata: host.wdata};
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        state_d   = START;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        if (sample) begin
          if ((state_q == ADDR_ACK || state_q == WACK) && sda) ack_err_d = 1'b1;
          if (state_q == RDATA) rdata_d = {rdata_q[6:0], sda};
        end
        // Bit counter wraps 0 -> 7 on its own when a byte phase ends.
        if (last) begin
          case (state_q)
            START:    state_d = ADDR;
            ADDR: begin
              bit_d = bit_q - 3'd1;
              if (bit_q == 3'd0) state_d = ADDR_ACK;
            end
            ADDR_ACK: state_d = ack_err_q ? STOP : ((req_q.rw == RW_READ) ? RDATA : WDATA);
            WDATA: begin
              bit_d = bit_q - 3'd1;
              if (bit_q == 3'd0) state_d = WACK;
            end
            RDATA: begin
              bit_d = bit_q - 3'd1;
              if (bit_q == 3'd0) state_d = RNACK;
            end
            WACK, RNACK: state_d = STOP;
            STOP:        state_d = DONE;
            default: ;
          endcase
        end
      end
    endcase
    txbyte = (state_d == ADDR) ? {req_q.addr, req_q.rw} : req_q.wdata;
    {scl_oe_d, sda_oe_d} = bus_drive(state_d, phase_n, txbyte[bit_d]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_q     <= 3'd7;
      req_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      sda_oe_q  <= sda_oe_d;
      scl_oe_q  <= scl_oe_d;
    end
  end

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign scl          = scl_oe_q ? 1'b0 : 1'bz;
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rdata   = rdata_q;
  assign host.ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: behavioural I2C slave on the pulled-up bus and a
// scoreboard of expected per-transaction results popped on each done pulse.
module tb_i2c_master_controller;
  import i2c_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int LAT_FULL = 80 * CLK_DIV + 1;
  localparam int LAT_NACK = 44 * CLK_DIV + 1;
  localparam int STRETCH  = 37;

  typedef struct {
    int         lat;
    logic       ack_err;
    logic       is_rd;
    logic [7:0] rdata;
    logic       chk_cap;
    logic [7:0] cap;
  } exp_t;

  logic clk, rst_n;
  wire  sda, scl;
  logic sl_oe, tb_scl_oe;

  i2c_master_controller_if host();

  i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host),
    .sda   (sda),
    .scl   (scl)
  );

  pullup pu_sda (sda);
  pullup pu_scl (scl);
  assign sda = sl_oe     ? 1'b0 : 1'bz;
  assign scl = tb_scl_oe ? 1'b0 : 1'bz;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Behavioural slave: ACKs SLAVE_ADDR, captures write bytes, returns 8'hCC on reads.
  typedef enum {S_IGN, S_ADR, S_WR, S_RD} sph_e;
  sph_e       sph = S_IGN;
  int         bitc = 0;
  int         stop_cnt = 0;
  logic       scl_p = 1'b1, sda_p = 1'b1, scl_r, sda_r;
  logic       matched = 1'b0, rdm = 1'b0, s_nack = 1'b0;
  logic [7:0] sh = '0, cap = '0, tx;

  always @(negedge clk) begin
    scl_r = scl;
    sda_r = sda;
    if (scl_p && scl_r && sda_p && !sda_r) begin
      sph = S_ADR; bitc = 0; sl_oe = 1'b0; s_nack = 1'b0;
    end else if (scl_p && scl_r && !sda_p && sda_r) begin
      sph = S_IGN; sl_oe = 1'b0; stop_cnt++;
    end else if (!scl_p && scl_r) begin
      if ((sph == S_ADR || sph == S_WR) && bitc < 8) sh = {sh[6:0], sda_r};
      if (sph == S_RD && bitc == 8) s_nack = sda_r;
      bitc++;
    end else if (scl_p && !scl_r) begin
      if (bitc == 9) begin
        sl_oe = 1'b0;
        bitc  = 0;
        if (sph == S_ADR && matched) sph = rdm ? S_RD : S_WR;
        else sph = S_IGN;
        if (sph == S_RD) sl_oe = ~tx[7];
      end else if (bitc == 8) begin
        if (sph == S_ADR) begin
          matched = (sh[7:1] == SLAVE_ADDR); rdm = sh[0]; sl_oe = matched;
        end else if (sph == S_WR) begin
          cap = sh; sl_oe = 1'b1;
        end else sl_oe = 1'b0;
      end else if (sph == S_RD && bitc >= 1 && bitc <= 7) sl_oe = ~tx[7-bitc];
    end
    scl_p = scl_r;
    sda_p = sda_r;
  end

  // Monitor: timestamps accept/done and scores each finished transaction.
  exp_t exp_q[$];
  int   t_acc = 0, t_done = 0, acc_cnt = 0, done_cnt = 0, stop_at_acc = 0;
  logic busy_p = 1'b0, done_p = 1'b0;

  always @(negedge clk) begin
    if (rst_n && host.busy && !busy_p) begin
      t_acc = cyc; stop_at_acc = stop_cnt; acc_cnt++;
    end
    if (done_p) chk("done_pulse_width", host.done, 0);
    if (host.done) begin
      exp_t e;
      done_cnt++;
      t_done = cyc;
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("latency", cyc - t_acc, e.lat);
        chk("ack_err", host.ack_err, e.ack_err);
        chk("busy_at_done", host.busy, 0);
        chk("stop_seen", stop_cnt - stop_at_acc, 1);
        if (e.is_rd) begin
          chk("rdata", host.rdata, e.rdata);
          chk("master_nack", s_nack, 1);
        end
        if (e.chk_cap) chk("slave_cap", cap, e.cap);
      end
    end
    busy_p = host.busy;
    done_p = host.done;
  end

  function automatic exp_t mk(int lat, logic ae, logic rd, logic [7:0] rv, logic cc, logic [7:0] cv);
    exp_t e;
    e.lat = lat; e.ack_err = ae; e.is_rd = rd; e.rdata = rv; e.chk_cap = cc; e.cap = cv;
    return e;
  endfunction

  task automatic drive_req(input logic [6:0] a, input logic r, input logic [7:0] w);
    host.req = 1'b1; host.addr = a; host.rw = r; host.wdata = w;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", done_cnt >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] w, input exp_t e);
    int n0 = done_cnt;
    exp_q.push_back(e);
    @(negedge clk);
    drive_req(a, r, w);
    @(negedge clk);
    host.req = 1'b0;
    wait_done(n0 + 1);
  endtask

  initial begin
    int n0, a0, d0, x, k;
    tx = 8'hCC;
    sl_oe = 1'b0; tb_scl_oe = 1'b0;
    rst_n = 1'b0;
    host.req = 1'b0; host.addr = '0; host.rw = 1'b0; host.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", host.busy, 0);
    chk("rst_done", host.done, 0);
    chk("rst_ack_err", host.ack_err, 0);
    chk("rst_rdata", host.rdata, 0);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_txn(SLAVE_ADDR, RW_WRITE, 8'hA5, mk(LAT_FULL, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5));
    do_txn(SLAVE_ADDR, RW_READ,  8'h00, mk(LAT_FULL, 1'b0, 1'b1, 8'hCC, 1'b0, 8'h00));
    do_txn(7'h11,      RW_WRITE, 8'h77, mk(LAT_NACK, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00));
    repeat (5) @(negedge clk);
    chk("ack_err_hold", host.ack_err, 1);

    // req held high: second transaction may only start the cycle after done.
    n0 = done_cnt; a0 = acc_cnt;
    exp_q.push_back(mk(LAT_FULL, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C));
    exp_q.push_back(mk(LAT_FULL, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A));
    @(negedge clk);
    drive_req(SLAVE_ADDR, RW_WRITE, 8'h3C);
    @(negedge clk);
    host.wdata = 8'h5A;
    k = 0;
    while (acc_cnt < a0 + 2 && k < 3000) begin @(negedge clk); k++; end
    chk("b2b_second_accept", acc_cnt, a0 + 2);
    chk("b2b_gap", t_acc - t_done, 1);
    host.req = 1'b0;
    wait_done(n0 + 2);
    chk("b2b_accepts", acc_cnt, a0 + 2);

    // Reset in quarter 1 of the first address bit.
    d0 = done_cnt;
    @(negedge clk);
    drive_req(SLAVE_ADDR, RW_WRITE, 8'hF0);
    @(negedge clk);
    host.req = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_scl_low", scl, 0);
    chk("pre_rst_busy", host.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_busy", host.busy, 0);
    chk("mid_rst_done", host.done, 0);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);

    // SCL held low by the bench over write bit 3 (bus quarter 2 starts 232 clks after accept).
    n0 = done_cnt;
`ifdef I2C_CLK_STRETCH_EN
    exp_q.push_back(mk(LAT_FULL + STRETCH, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96));
`else
    exp_q.push_back(mk(LAT_FULL, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96));
`endif
    @(negedge clk);
    x = cyc;
    drive_req(SLAVE_ADDR, RW_WRITE, 8'h96);
    @(negedge clk);
    host.req = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    while (cyc < x + 1 + 229) @(negedge clk);
    tb_scl_oe = 1'b1;
    while (cyc < x + 1 + 229 + 40) @(negedge clk);
    tb_scl_oe = 1'b0;
`endif
    wait_done(n0 + 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
